multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multicycle main control FSM for the 16-bit processor datapath. Sequences fetch, decode, execute, memory and write-back for each instruction. Drives the `alu_op` code consumed by the ALU control decoder, plus all datapath mux selects and register/memory enables. Sits between the instruction register's opcode field and the datapath; waits on a memory ready handshake.

## Interface
- No parameters; opcode and state encodings come from the shared package.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `opcode` in 4: instruction bits [15:12], valid from the IR after FETCH.
- `mem_rdy` in 1: memory has completed the current read or write this cycle.
- `pc_write` out 1: unconditional PC load.
- `pc_write_cond` out 1: PC load if the ALU zero flag is set.
- `iord` out 1: memory address select, 0=PC, 1=ALUOut.
- `mem_read` out 1: memory read request.
- `mem_write` out 1: memory write request.
- `ir_write` out 1: IR load.
- `mem_to_reg` out 1: write-back data select, 0=ALUOut, 1=MDR.
- `reg_write` out 1: register file write.
- `reg_dst` out 1: destination select, 0=rt, 1=rd.
- `alu_src_a` out 1: ALU A select, 0=PC, 1=regA.
- `alu_src_b` out 2: ALU B select, 0=regB, 1=const 2, 2=sign-ext imm, 3=sign-ext imm<<1.
- `alu_op` out 2: 0=add, 1=sub, 2=use func, 3=or.
- `pc_source` out 2: 0=ALU result, 1=ALUOut, 2=jump target.
- `halted` out 1: FSM is in HALT.
- `illegal` out 1: one-cycle pulse when an undefined opcode is decoded.

## Operation
- Opcodes: 0 R-type, 1 ADDI, 2 LW, 3 SW, 4 BEQ, 5 ORI, 6 J, 7 HALT; 8–15 illegal.
- Moore FSM: outputs depend on the registered state only. The sole exception is `illegal`, which is DECODE && opcode ≥ 8. Every output not listed for a state is 0.
- FETCH: `mem_read`, `iord`=0. Stays in FETCH while `mem_rdy`=0. When `mem_rdy`=1 it also asserts `ir_write`, `pc_write`, `alu_src_a`=0, `alu_src_b`=1, `alu_op`=0, `pc_source`=0, then goes to DECODE. IR and PC update only on the ready cycle.
- DECODE: `alu_src_a`=0, `alu_src_b`=3, `alu_op`=0 (branch target into ALUOut).
  - Next state: R→EXEC, ADDI→IEXEC_ADD, ORI→IEXEC_OR, LW/SW→MEMADR, BEQ→BRANCH, J→JUMP, HALT→HALT, illegal→FETCH.
- EXEC: `alu_src_a`=1, `alu_src_b`=0, `alu_op`=2 → RWB.
- RWB: `reg_write`, `reg_dst`=1, `mem_to_reg`=0 → FETCH.
- IEXEC_ADD / IEXEC_OR: `alu_src_a`=1, `alu_src_b`=2, `alu_op`=0 / 3 → IWB.
- IWB: `reg_write`, `reg_dst`=0, `mem_to_reg`=0 → FETCH.
- MEMADR: `alu_src_a`=1, `alu_src_b`=2, `alu_op`=0 → MEMRD for LW, MEMWR for SW.
- MEMRD: `mem_read`, `iord`=1. Holds until `mem_rdy`, then → MEMWB.
- MEMWB: `reg_write`, `reg_dst`=0, `mem_to_reg`=1 → FETCH.
- MEMWR: `mem_write`, `iord`=1. Holds until `mem_rdy`, then → FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=0, `alu_op`=1, `pc_write_cond`, `pc_source`=1 → FETCH.
- JUMP: `pc_write`, `pc_source`=2 → FETCH.
- HALT: `halted`=1. Absorbing; left only by reset.
- Decode of `opcode` happens only in DECODE and MEMADR. `opcode` changes in other states are ignored.

## Timing
- Reset: state=FETCH asynchronously. Outputs are those of FETCH with `mem_rdy`=0: `mem_read`=1, everything else 0, `halted`=0.
- Reset mid-operation aborts the instruction; no partial write-back. Assertion during MEMWR drops `mem_write` immediately.
- Cycle counts with zero-wait memory:
  - R, ADDI, ORI: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ, J: 3 cycles.
  - Illegal: 2 cycles.
- Each wait cycle (`mem_rdy`=0 in FETCH, MEMRD or MEMWR) adds exactly one cycle. Request signals hold stable throughout the wait.
- `mem_read` and `mem_write` are never high together.
- `pc_write` and `pc_write_cond` are never high together.

## Structure
- Shared package `cpu_pkg`: opcode constants, `alu_op` codes (ADD=0, SUB=1, FUNC=2, OR=3), `alu_src_b` and `pc_source` encodings, state enum (4-bit).
- The ALU control decoder consumes `alu_op` and stays a separate instance.
- Natural sub-module: `control_output_decode`, a combinational state→control-word decoder. The FSM next-state logic stays in `multicycle_control`.

## Test plan
- Reset asserted in MEMRD with `mem_rdy`=0 → next observation shows state FETCH, `mem_read`=1, `iord`=0, `reg_write`=0.
- R-type (opcode 0), `mem_rdy` tied 1 → 4 cycles. `alu_op`=2 in EXEC, then `reg_write`=1 with `reg_dst`=1, then back to FETCH.
- LW with 2 wait cycles in MEMRD → 7 cycles total. `mem_read`=1 and `iord`=1 held for 3 cycles, then `mem_to_reg`=1 with `reg_write`=1.
- BEQ → BRANCH cycle shows `alu_op`=1, `alu_src_b`=0, `pc_write_cond`=1, `pc_source`=1. Check that `pc_write`=0.
- Opcode 9 → `illegal` pulses for 1 cycle in DECODE, FSM returns to FETCH, no enable asserted.
- Opcode 7 → `halted`=1 and all enables 0 for 100 cycles regardless of `mem_rdy`/`opcode`. Release via reset only.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit multicycle processor control path:
// opcodes, datapath select encodings, control FSM states and the control word.
package cpu_pkg;

  // Opcode field, instruction bits [15:12]; values 8..15 are undefined.
  localparam logic [3:0] OpRtype = 4'd0;
  localparam logic [3:0] OpAddi  = 4'd1;
  localparam logic [3:0] OpLw    = 4'd2;
  localparam logic [3:0] OpSw    = 4'd3;
  localparam logic [3:0] OpBeq   = 4'd4;
  localparam logic [3:0] OpOri   = 4'd5;
  localparam logic [3:0] OpJ     = 4'd6;
  localparam logic [3:0] OpHalt  = 4'd7;

  // alu_op codes consumed by the ALU control decoder.
  localparam logic [1:0] AluAdd  = 2'd0;
  localparam logic [1:0] AluSub  = 2'd1;
  localparam logic [1:0] AluFunc = 2'd2;
  localparam logic [1:0] AluOr   = 2'd3;

  // ALU B operand select.
  localparam logic [1:0] SrcBRegB   = 2'd0;
  localparam logic [1:0] SrcBConst2 = 2'd1;
  localparam logic [1:0] SrcBImm    = 2'd2;
  localparam logic [1:0] SrcBImmSh  = 2'd3;

  // Next-PC source select.
  localparam logic [1:0] PcSrcAlu    = 2'd0;
  localparam logic [1:0] PcSrcAluOut = 2'd1;
  localparam logic [1:0] PcSrcJump   = 2'd2;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StExec,
    StRwb,
    StIexecAdd,
    StIexecOr,
    StIwb,
    StMemAdr,
    StMemRd,
    StMemWb,
    StMemWr,
    StBranch,
    StJump,
    StHalt
  } state_e;

  // Full set of datapath controls produced for one state.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       halted;
  } ctrl_t;

  // Opcodes with bit 3 set have no defined instruction.
  function automatic logic is_illegal(logic [3:0] op);
    return op[3];
  endfunction

endpackage

// File: rtl/control_output_decode.sv
// Combinational state -> control word decoder for the multicycle control FSM.
// Only FETCH looks at mem_rdy: IR and PC load solely on the ready cycle.
module control_output_decode
  import cpu_pkg::*;
(
  input  state_e state,
  input  logic   mem_rdy,
  output ctrl_t  ctrl
);

  // Decode the current state into the datapath control word; unlisted fields stay 0.
  always_comb begin
    ctrl = '0;
    unique case (state)
      StFetch: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b0;
        if (mem_rdy) begin
          ctrl.ir_write  = 1'b1;
          ctrl.pc_write  = 1'b1;
          ctrl.alu_src_a = 1'b0;
          ctrl.alu_src_b = SrcBConst2;
          ctrl.alu_op    = AluAdd;
          ctrl.pc_source = PcSrcAlu;
        end
      end
      StDecode: begin
        // Branch target computed speculatively into ALUOut.
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SrcBImmSh;
        ctrl.alu_op    = AluAdd;
      end
      StExec: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SrcBRegB;
        ctrl.alu_op    = AluFunc;
      end
      StRwb: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.mem_to_reg = 1'b0;
      end
      StIexecAdd: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SrcBImm;
        ctrl.alu_op    = AluAdd;
      end
      StIexecOr: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SrcBImm;
        ctrl.alu_op    = AluOr;
      end
      StIwb: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b0;
      end
      StMemAdr: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SrcBImm;
        ctrl.alu_op    = AluAdd;
      end
      StMemRd: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      StMemWb: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b1;
      end
      StMemWr: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      StBranch: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SrcBRegB;
        ctrl.alu_op        = AluSub;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PcSrcAluOut;
      end
      StJump: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PcSrcJump;
      end
      StHalt: begin
        ctrl.halted = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle main control FSM: sequences fetch, decode, execute, memory and
// write-back, and drives all datapath selects and enables from the current state.
module multicycle_control
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] opcode,
  input  logic       mem_rdy,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       halted,
  output logic       illegal
);

  state_e state_q;
  ctrl_t  ctrl;

  // State register and next-state selection; opcode is only consulted in DECODE and MEMADR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
    end else begin
      case (state_q)
        StFetch:  if (mem_rdy) state_q <= StDecode;
        StDecode: begin
          case (opcode)
            OpRtype: state_q <= StExec;
            OpAddi:  state_q <= StIexecAdd;
            OpOri:   state_q <= StIexecOr;
            OpLw:    state_q <= StMemAdr;
            OpSw:    state_q <= StMemAdr;
            OpBeq:   state_q <= StBranch;
            OpJ:     state_q <= StJump;
            OpHalt:  state_q <= StHalt;
            default: state_q <= StFetch;
          endcase
        end
        StExec:     state_q <= StRwb;
        StRwb:      state_q <= StFetch;
        StIexecAdd: state_q <= StIwb;
        StIexecOr:  state_q <= StIwb;
        StIwb:      state_q <= StFetch;
        StMemAdr:   state_q <= (opcode == OpLw) ? StMemRd : StMemWr;
        StMemRd:    if (mem_rdy) state_q <= StMemWb;
        StMemWb:    state_q <= StFetch;
        StMemWr:    if (mem_rdy) state_q <= StFetch;
        StBranch:   state_q <= StFetch;
        StJump:     state_q <= StFetch;
        StHalt:     state_q <= StHalt;
        default:    state_q <= StFetch;
      endcase
    end
  end

  control_output_decode u_decode (
    .state   (state_q),
    .mem_rdy (mem_rdy),
    .ctrl    (ctrl)
  );

  // Unpack the control word onto the datapath ports.
  always_comb begin
    pc_write      = ctrl.pc_write;
    pc_write_cond = ctrl.pc_write_cond;
    iord          = ctrl.iord;
    mem_read      = ctrl.mem_read;
    mem_write     = ctrl.mem_write;
    ir_write      = ctrl.ir_write;
    mem_to_reg    = ctrl.mem_to_reg;
    reg_write     = ctrl.reg_write;
    reg_dst       = ctrl.reg_dst;
    alu_src_a     = ctrl.alu_src_a;
    alu_src_b     = ctrl.alu_src_b;
    alu_op        = ctrl.alu_op;
    pc_source     = ctrl.pc_source;
    halted        = ctrl.halted;
    illegal       = (state_q == StDecode) && is_illegal(opcode);
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: every cycle's expected control word is
// queued when the inputs are driven and compared against the DUT at the negedge.
module tb_multicycle_control;

  logic       clk;
  logic       rst_n;
  logic [3:0] opcode;
  logic       mem_rdy;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_write, reg_dst, alu_src_a, halted, illegal;
  logic [1:0] alu_src_b, alu_op, pc_source;

  multicycle_control dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .mem_rdy       (mem_rdy),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .reg_dst       (reg_dst),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .halted        (halted),
    .illegal       (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [17:0] obs;
  assign obs = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
                reg_write, reg_dst, alu_src_a, alu_src_b, alu_op, pc_source, halted, illegal};

  typedef struct {
    logic [17:0] exp;
    string       tag;
  } item_t;

  item_t sb[$];
  int    total = 0;
  int    bad = 0;

  function automatic logic [17:0] mk(input logic pcw, input logic pcwc, input logic io,
                                     input logic mr, input logic mw, input logic irw,
                                     input logic m2r, input logic rw, input logic rd,
                                     input logic asa, input logic [1:0] asb,
                                     input logic [1:0] aop, input logic [1:0] psrc,
                                     input logic hlt, input logic ill);
    return {pcw, pcwc, io, mr, mw, irw, m2r, rw, rd, asa, asb, aop, psrc, hlt, ill};
  endfunction

  logic [17:0] e_fetch_wait, e_fetch_rdy, e_decode, e_decode_ill, e_exec, e_rwb;
  logic [17:0] e_iexec_add, e_iexec_or, e_iwb, e_memadr, e_memrd, e_memwb, e_memwr;
  logic [17:0] e_branch, e_jump, e_halt;

  task automatic check_head();
    item_t it;
    it = sb.pop_front();
    total++;
    assert (obs === it.exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", it.tag, obs, it.exp);
    end
  endtask

  // Drive one cycle of inputs, queue the expected outputs, check at the negedge.
  task automatic cyc(input logic rdy, input logic [3:0] op, input logic [17:0] e,
                     input string tag);
    item_t it;
    mem_rdy = rdy;
    opcode  = op;
    it.exp  = e;
    it.tag  = tag;
    sb.push_back(it);
    @(negedge clk);
    check_head();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset mid-cycle: outputs must fall back to FETCH at once.
  task automatic rst_pulse(input string tag);
    item_t it;
    rst_n   = 1'b0;
    mem_rdy = 1'b0;
    it.exp  = e_fetch_wait;
    it.tag  = tag;
    sb.push_back(it);
    #1;
    check_head();
    it.tag = {tag, "_hold"};
    sb.push_back(it);
    @(negedge clk);
    check_head();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    //                   pcw pcc io mr mw irw m2r rw rd asa asb   aop   psrc  h  ill
    e_fetch_wait = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0, 0);
    e_fetch_rdy  = mk(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'd1, 2'd0, 2'd0, 0, 0);
    e_decode     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd3, 2'd0, 2'd0, 0, 0);
    e_decode_ill = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd3, 2'd0, 2'd0, 0, 1);
    e_exec       = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd2, 2'd0, 0, 0);
    e_rwb        = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'd0, 2'd0, 2'd0, 0, 0);
    e_iexec_add  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 2'd0, 2'd0, 0, 0);
    e_iexec_or   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 2'd3, 2'd0, 0, 0);
    e_iwb        = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 0, 0);
    e_memadr     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 2'd0, 2'd0, 0, 0);
    e_memrd      = mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0, 0);
    e_memwb      = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2'd0, 2'd0, 2'd0, 0, 0);
    e_memwr      = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0, 0);
    e_branch     = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd1, 2'd1, 0, 0);
    e_jump       = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd2, 0, 0);
    e_halt       = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 1, 0);

    // Reset state
    rst_n   = 1'b0;
    mem_rdy = 1'b0;
    opcode  = 4'd0;
    sb.push_back('{e_fetch_wait, "reset"});
    @(negedge clk);
    check_head();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // R-type, zero wait; opcode change in EXEC must be ignored
    cyc(1'b1, 4'd0, e_fetch_rdy, "r_fetch");
    cyc(1'b1, 4'd0, e_decode,    "r_decode");
    cyc(1'b1, 4'd3, e_exec,      "r_exec");
    cyc(1'b1, 4'd3, e_rwb,       "r_rwb");

    // LW with two wait cycles in MEMRD
    cyc(1'b1, 4'd2, e_fetch_rdy, "lw_fetch");
    cyc(1'b1, 4'd2, e_decode,    "lw_decode");
    cyc(1'b1, 4'd2, e_memadr,    "lw_memadr");
    cyc(1'b0, 4'd2, e_memrd,     "lw_memrd_w1");
    cyc(1'b0, 4'd2, e_memrd,     "lw_memrd_w2");
    cyc(1'b1, 4'd2, e_memrd,     "lw_memrd_rdy");
    cyc(1'b1, 4'd2, e_memwb,     "lw_memwb");

    // SW with a fetch wait and a MEMWR wait
    cyc(1'b0, 4'd3, e_fetch_wait, "sw_fetch_wait");
    cyc(1'b1, 4'd3, e_fetch_rdy,  "sw_fetch");
    cyc(1'b1, 4'd3, e_decode,     "sw_decode");
    cyc(1'b1, 4'd3, e_memadr,     "sw_memadr");
    cyc(1'b0, 4'd3, e_memwr,      "sw_memwr_w1");
    cyc(1'b1, 4'd3, e_memwr,      "sw_memwr_rdy");

    // ADDI and ORI
    cyc(1'b1, 4'd1, e_fetch_rdy, "addi_fetch");
    cyc(1'b1, 4'd1, e_decode,    "addi_decode");
    cyc(1'b1, 4'd1, e_iexec_add, "addi_exec");
    cyc(1'b1, 4'd1, e_iwb,       "addi_wb");
    cyc(1'b1, 4'd5, e_fetch_rdy, "ori_fetch");
    cyc(1'b1, 4'd5, e_decode,    "ori_decode");
    cyc(1'b1, 4'd5, e_iexec_or,  "ori_exec");
    cyc(1'b1, 4'd5, e_iwb,       "ori_wb");

    // BEQ and J
    cyc(1'b1, 4'd4, e_fetch_rdy, "beq_fetch");
    cyc(1'b1, 4'd4, e_decode,    "beq_decode");
    cyc(1'b1, 4'd4, e_branch,    "beq_branch");
    cyc(1'b1, 4'd6, e_fetch_rdy, "j_fetch");
    cyc(1'b1, 4'd6, e_decode,    "j_decode");
    cyc(1'b1, 4'd6, e_jump,      "j_jump");

    // Illegal opcode 9: pulse only in DECODE, then back to FETCH
    cyc(1'b1, 4'd9, e_fetch_rdy,  "ill_fetch");
    cyc(1'b1, 4'd9, e_decode_ill, "ill_decode");
    cyc(1'b0, 4'd9, e_fetch_wait, "ill_back_fetch");

    // Reset while waiting in MEMRD
    cyc(1'b1, 4'd2, e_fetch_rdy, "lw2_fetch");
    cyc(1'b1, 4'd2, e_decode,    "lw2_decode");
    cyc(1'b1, 4'd2, e_memadr,    "lw2_memadr");
    cyc(1'b0, 4'd2, e_memrd,     "lw2_memrd_w1");
    rst_pulse("rst_memrd");
    cyc(1'b1, 4'd2, e_fetch_rdy, "after_rst_memrd");
    cyc(1'b1, 4'd2, e_decode,    "after_rst_decode");
    cyc(1'b1, 4'd3, e_memadr,    "sw2_memadr");

    // Reset while waiting in MEMWR drops mem_write immediately
    cyc(1'b0, 4'd3, e_memwr, "sw2_memwr_w1");
    rst_pulse("rst_memwr");

    // HALT is absorbing regardless of mem_rdy and opcode
    cyc(1'b1, 4'd7, e_fetch_rdy, "halt_fetch");
    cyc(1'b1, 4'd7, e_decode,    "halt_decode");
    for (int i = 0; i < 100; i++) begin
      cyc(1'($urandom), 4'($urandom), e_halt, "halt_hold");
    end
    rst_pulse("rst_halt");
    cyc(1'b1, 4'd0, e_fetch_rdy, "post_halt_fetch");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
